// File: rtl/bypass_pkg.sv
// rtl/bypass_pkg.sv - shared constants and entry layout for the operand-bypass controller
package bypass_pkg;

    localparam int SLOT_E     = 0;
    localparam int SLOT_M     = 1;
    localparam int SLOT_W     = 2;
    localparam int SEL_GRF    = 0;

    localparam int DEF_STAGES = 3;
    localparam int DEF_AW     = 5;
    localparam int DEF_LW     = $clog2(DEF_STAGES + 1);

    typedef struct packed {
        logic              valid;
        logic [DEF_AW-1:0] waddr;
        logic [DEF_LW-1:0] rem;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic int lw_for(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/bypass_slot.sv
// rtl/bypass_slot.sv - one pending-write entry with shift-in, rem countdown and per-port compare
module bypass_slot
    import bypass_pkg::*;
#(
    parameter int NREAD = 2,
    parameter int AW    = 5,
    parameter int LW    = 2,
    parameter bit DEC   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    input  logic [AW-1:0]    i_waddr,
    input  logic [LW-1:0]    i_rem,
    input  logic [NREAD*AW-1:0] i_rd_addr,
    output logic             o_valid,
    output logic [AW-1:0]    o_waddr,
    output logic [LW-1:0]    o_rem,
    output logic [NREAD-1:0] o_hit,
    output logic [NREAD-1:0] o_ready
);

    logic          r_valid;
    logic [AW-1:0] r_waddr;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] w_rem_in;

    // The E slot takes issue_lat as-is; later slots count down one per shift.
    assign w_rem_in = (DEC && (i_rem != '0)) ? i_rem - 1'b1 : i_rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_waddr <= '0;
            r_rem   <= '0;
        end else begin
            r_valid <= i_valid;
            r_waddr <= i_waddr;
            r_rem   <= w_rem_in;
        end
    end

    assign o_valid = r_valid;
    assign o_waddr = r_waddr;
    assign o_rem   = r_rem;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        assign o_hit[p]   = r_valid && (r_waddr == i_rd_addr[p*AW +: AW]) &&
                            (i_rd_addr[p*AW +: AW] != '0);
        assign o_ready[p] = (r_rem == '0);
    end

endmodule

// File: rtl/bypass_ctrl.sv
// rtl/bypass_ctrl.sv - tracks pending writes across STAGES slots, drives forwarding selects and stall
module bypass_ctrl
    import bypass_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int LW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_waddr,
    input  logic [LW-1:0]        issue_lat,
    input  logic                 flush,
    input  logic [NREAD*AW-1:0]  rd_addr,
    input  logic [NREAD*DW-1:0]  reg_data,
    input  logic [STAGES*DW-1:0] stage_data,
    output logic [NREAD*LW-1:0]  fwd_sel,
    output logic [NREAD*DW-1:0]  fwd_data,
    output logic                 stall,
    output logic [15:0]          stall_cnt
);

    logic [STAGES-1:0]       w_valid;
    logic [STAGES*AW-1:0]    w_waddr;
    logic [STAGES*LW-1:0]    w_rem;
    logic [STAGES*NREAD-1:0] w_hit;
    logic [STAGES*NREAD-1:0] w_ready;
    logic [NREAD-1:0]        w_req;
    logic                    w_load;
    logic                    w_unused;
    logic [15:0]             r_stall_cnt;

    assign w_load = issue_valid && !stall && !flush && (issue_waddr != '0);

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        if (i == 0) begin : g_e
            bypass_slot #(.NREAD(NREAD), .AW(AW), .LW(LW), .DEC(1'b0)) u_slot (
                .clk       (clk),
                .resetn    (reset),
                .i_valid   (w_load),
                .i_waddr   (issue_waddr),
                .i_rem     (issue_lat),
                .i_rd_addr (rd_addr),
                .o_valid   (w_valid[i]),
                .o_waddr   (w_waddr[i*AW +: AW]),
                .o_rem     (w_rem[i*LW +: LW]),
                .o_hit     (w_hit[i*NREAD +: NREAD]),
                .o_ready   (w_ready[i*NREAD +: NREAD])
            );
        end else begin : g_n
            bypass_slot #(.NREAD(NREAD), .AW(AW), .LW(LW), .DEC(1'b1)) u_slot (
                .clk       (clk),
                .resetn    (reset),
                .i_valid   (w_valid[i-1]),
                .i_waddr   (w_waddr[(i-1)*AW +: AW]),
                .i_rem     (w_rem[(i-1)*LW +: LW]),
                .i_rd_addr (rd_addr),
                .o_valid   (w_valid[i]),
                .o_waddr   (w_waddr[i*AW +: AW]),
                .o_rem     (w_rem[i*LW +: LW]),
                .o_hit     (w_hit[i*NREAD +: NREAD]),
                .o_ready   (w_ready[i*NREAD +: NREAD])
            );
        end
    end

    // The W entry retires into the register file; its shift-out has no consumer.
    assign w_unused = ^{w_valid[STAGES-1], w_waddr[(STAGES-1)*AW +: AW], w_rem[(STAGES-1)*LW +: LW]};

    // Walk oldest to youngest so the youngest matching slot has the final say.
    always_comb begin
        fwd_sel  = '0;
        fwd_data = reg_data;
        w_req    = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (w_hit[i*NREAD + p]) begin
                    if (w_ready[i*NREAD + p]) begin
                        fwd_sel[p*LW +: LW]  = LW'(i + 1);
                        fwd_data[p*DW +: DW] = stage_data[i*DW +: DW];
                        w_req[p]             = 1'b0;
                    end else begin
                        fwd_sel[p*LW +: LW]  = LW'(SEL_GRF);
                        fwd_data[p*DW +: DW] = reg_data[p*DW +: DW];
                        w_req[p]             = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = |w_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_bypass_ctrl.sv
// tb/tb_bypass_ctrl.sv - table-driven scoreboard bench for bypass_ctrl plus saturation run
module tb_bypass_ctrl;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic [1:0]  issue_lat;
    logic        flush;
    logic [9:0]  rd_addr;
    logic [63:0] reg_data;
    logic [95:0] stage_data;
    logic [3:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic        stall;
    logic [15:0] stall_cnt;

    logic         s_reset;
    logic [4:0]   s_rd_addr;
    logic [7:0]   s_reg_data;
    logic [127:0] s_stage_data;
    logic [4:0]   s_fwd_sel;
    logic [7:0]   s_fwd_data;
    logic         s_stall;
    logic [15:0]  s_stall_cnt;

    bypass_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .reg_data    (reg_data),
        .stage_data  (stage_data),
        .fwd_sel     (fwd_sel),
        .fwd_data    (fwd_data),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    bypass_ctrl #(.NREAD(1), .STAGES(16), .AW(5), .DW(8), .LW(5)) u_sat (
        .clk         (clk),
        .reset       (s_reset),
        .issue_valid (1'b1),
        .issue_waddr (5'd3),
        .issue_lat   (5'd31),
        .flush       (1'b0),
        .rd_addr     (s_rd_addr),
        .reg_data    (s_reg_data),
        .stage_data  (s_stage_data),
        .fwd_sel     (s_fwd_sel),
        .fwd_data    (s_fwd_data),
        .stall       (s_stall),
        .stall_cnt   (s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [4:0] wa;
        logic [1:0] lat;
        logic       fl;
        logic [4:0] rd0;
        logic [4:0] rd1;
        logic       st;
        logic [1:0] s0;
        logic [1:0] s1;
    } vec_t;

    typedef struct {
        int          row;
        logic        stall;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [15:0] cnt;
    } exp_t;

    localparam int NVEC = 25;
    vec_t vt [NVEC];
    exp_t sb [$];
    int   total  = 0;
    int   passed = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input int iv, input int wa, input int lat, input int fl,
                                input int rd0, input int rd1, input int st, input int s0, input int s1);
        vec_t v;
        v.iv = iv[0];   v.wa = wa[4:0];   v.lat = lat[1:0]; v.fl = fl[0];
        v.rd0 = rd0[4:0]; v.rd1 = rd1[4:0]; v.st = st[0];
        v.s0 = s0[1:0]; v.s1 = s1[1:0];
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [1:0] sel, input int port, input int k);
        if (sel == 2'd0) return 32'((port == 0 ? 32'h1000_0000 : 32'h2000_0000) + k);
        return 32'(32'hE000_0000 + ((int'(sel) - 1) << 16) + k);
    endfunction

    task automatic apply(input vec_t v, input int k);
        exp_t e;
        issue_valid = v.iv;
        issue_waddr = v.wa;
        issue_lat   = v.lat;
        flush       = v.fl;
        rd_addr     = {v.rd1, v.rd0};
        reg_data    = {32'(32'h2000_0000 + k), 32'(32'h1000_0000 + k)};
        stage_data  = {32'(32'hE002_0000 + k), 32'(32'hE001_0000 + k), 32'(32'hE000_0000 + k)};
        e.row = k; e.stall = v.st; e.sel0 = v.s0; e.sel1 = v.s1;
        e.d0 = exp_data(v.s0, 0, k);
        e.d1 = exp_data(v.s1, 1, k);
        e.cnt = exp_cnt;
        sb.push_back(e);
        if (v.st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("row%0d stall", e.row), {31'd0, stall}, {31'd0, e.stall});
        chk($sformatf("row%0d sel0", e.row), {30'd0, fwd_sel[1:0]}, {30'd0, e.sel0});
        chk($sformatf("row%0d sel1", e.row), {30'd0, fwd_sel[3:2]}, {30'd0, e.sel1});
        chk($sformatf("row%0d data0", e.row), fwd_data[31:0], e.d0);
        chk($sformatf("row%0d data1", e.row), fwd_data[63:32], e.d1);
        chk($sformatf("row%0d stall_cnt", e.row), {16'd0, stall_cnt}, {16'd0, e.cnt});
        @(posedge clk); #1;
    endtask

    initial begin
        int          bad;
        logic [15:0] m;
        vt[0]  = mk(1, 8, 0, 0,  0, 0,  0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0,  8, 0,  0, 1, 0);
        vt[2]  = mk(0, 0, 0, 0,  8, 0,  0, 2, 0);
        vt[3]  = mk(0, 0, 0, 0,  8, 8,  0, 3, 3);
        vt[4]  = mk(0, 0, 0, 0,  8, 0,  0, 0, 0);
        vt[5]  = mk(1, 9, 1, 0,  0, 0,  0, 0, 0);
        vt[6]  = mk(1, 10, 0, 0, 0, 9,  1, 0, 0);
        vt[7]  = mk(1, 10, 0, 0, 10, 9, 0, 0, 2);
        vt[8]  = mk(0, 0, 0, 0,  10, 9, 0, 1, 3);
        vt[9]  = mk(1, 4, 0, 0,  10, 0, 0, 2, 0);
        vt[10] = mk(1, 4, 0, 0,  4, 0,  0, 1, 0);
        vt[11] = mk(0, 0, 0, 0,  4, 4,  0, 1, 1);
        vt[12] = mk(0, 0, 0, 0,  4, 0,  0, 2, 0);
        vt[13] = mk(1, 0, 0, 0,  4, 0,  0, 3, 0);
        vt[14] = mk(1, 5, 0, 1,  0, 4,  0, 0, 0);
        vt[15] = mk(0, 0, 0, 0,  5, 0,  0, 0, 0);
        vt[16] = mk(1, 6, 2, 0,  0, 0,  0, 0, 0);
        vt[17] = mk(1, 7, 0, 1,  6, 7,  1, 0, 0);
        vt[18] = mk(1, 7, 0, 0,  6, 7,  1, 0, 0);
        vt[19] = mk(0, 0, 0, 0,  6, 7,  0, 3, 0);
        vt[20] = mk(0, 0, 0, 0,  6, 0,  0, 0, 0);
        vt[21] = mk(1, 11, 1, 0, 0, 0,  0, 0, 0);
        vt[22] = mk(1, 12, 0, 0, 11, 0, 1, 0, 0);
        vt[23] = mk(1, 12, 0, 0, 11, 0, 0, 2, 0);
        vt[24] = mk(0, 0, 0, 0,  11, 12, 0, 3, 1);

        s_reset = 1'b0; s_rd_addr = 5'd3; s_reg_data = 8'h5A; s_stage_data = '0;
        reset = 1'b0; issue_valid = 1'b1; issue_waddr = 5'd8; issue_lat = 2'd3; flush = 1'b0;
        rd_addr = {5'd0, 5'd8};
        reg_data = 64'h2000_0000_1000_0000;
        stage_data = {32'hE002_0000, 32'hE001_0000, 32'hE000_0000};

        @(posedge clk); #1;
        @(negedge clk);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset fwd_sel", {28'd0, fwd_sel}, 32'd0);
        chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset fwd_data0", fwd_data[31:0], 32'h1000_0000);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int k = 0; k < NVEC; k++) apply(vt[k], k);

        // Reset asserted while a lat3 producer holds the pipeline.
        issue_valid = 1'b1; issue_waddr = 5'd13; issue_lat = 2'd3; flush = 1'b0;
        rd_addr = {5'd0, 5'd0};
        @(posedge clk); #1;
        issue_valid = 1'b0; rd_addr = {5'd0, 5'd13}; reset = 1'b0;
        @(negedge clk);
        chk("midstall stall before reset", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midstall stall after reset", {31'd0, stall}, 32'd0);
        chk("midstall sel after reset", {28'd0, fwd_sel}, 32'd0);
        chk("midstall cnt after reset", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;

        // Saturation: 16 stalled cycles out of every 17 on the deep instance.
        s_reset = 1'b1;
        bad = 0;
        m = 16'd0;
        for (int c = 0; c < 69700; c++) begin
            @(negedge clk);
            if (s_stall !== ((c % 17) != 0)) bad++;
            if (c == 1700) chk("sat cnt midway", {16'd0, s_stall_cnt}, {16'd0, m});
            if (((c % 17) != 0) && m != 16'hFFFF) m = m + 16'd1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sat stall pattern", bad, 32'd0);
        chk("sat cnt saturated", {16'd0, s_stall_cnt}, {16'd0, m});
        chk("sat cnt ffff", {16'd0, s_stall_cnt}, 32'h0000_FFFF);
        @(posedge clk); #1;
        s_reset = 1'b0;
        @(posedge clk); #1;
        s_reset = 1'b1;
        @(negedge clk);
        chk("sat cnt after reset", {16'd0, s_stall_cnt}, 32'd0);
        chk("sat stall after reset", {31'd0, s_stall}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
